// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator result/display datapath.
package calc_pkg;

  localparam int unsigned BCD_DIGIT_W    = 4;
  localparam int unsigned ADD3_THRESH    = 5;
  localparam int unsigned DIGITS_DEFAULT = 3;

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit that is 5 or more, so the
// following left shift carries into the next digit instead of leaving a value above 9.
module bcd_add3
  import calc_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  // Correct the digit ahead of the shift
  always_comb begin
    dout = din;
    if (din >= BCD_DIGIT_W'(ADD3_THRESH)) begin
      dout = din + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3), one iteration per clock.
// Optional build macro RESULT_BCD_SIGNED_EN: treat value as two's complement,
// convert the magnitude and report the sign on neg. Without it neg is tied low.
module result_bcd_converter
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = DIGITS_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [WIDTH-1:0]              value,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          neg,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned BcdW = BCD_DIGIT_W * DIGITS;

  state_e              state_q;
  logic [WIDTH-1:0]    shreg_q;
  logic [BcdW-1:0]     scratch_q;
  logic [BcdW-1:0]     scratch_adj;
  logic [BcdW-1:0]     bcd_q;
  logic [CntW-1:0]     cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [BcdW+WIDTH-1:0] shifted;
  logic [WIDTH-1:0]    load_val;
  logic                load_sign;
  logic                last_iter;

  // Per-digit correction of the scratch digits before each shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign shifted   = {scratch_adj, shreg_q} << 1;
  assign last_iter = (cnt_q == CntW'(WIDTH - 1));

`ifdef RESULT_BCD_SIGNED_EN
  logic sign_q;
  logic neg_q;

  // Capture operand magnitude; 0x80-style minimum converts as its unsigned magnitude
  always_comb begin
    load_sign = value[WIDTH-1];
    load_val  = load_sign ? (~value + WIDTH'(1)) : value;
  end

  // Sign latched at capture, published together with the digits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      if (state_q == StIdle && start) sign_q <= load_sign;
      if (state_q == StShift && last_iter) neg_q <= sign_q;
    end
  end

  assign neg = neg_q;
`else
  // Unsigned operand: load as-is
  always_comb begin
    load_sign = 1'b0;
    load_val  = value;
  end

  assign neg = load_sign;
`endif

  // Conversion FSM and datapath registers; outputs only change on the final edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            shreg_q   <= load_val;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          scratch_q <= shifted[BcdW+WIDTH-1:WIDTH];
          shreg_q   <= shifted[WIDTH-1:0];
          if (last_iter) begin
            bcd_q   <= shifted[BcdW+WIDTH-1:WIDTH];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bcd  = bcd_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
